// File: rtl/aes_pkg.sv
// Shared AES-128 constants, types and GF(2^8) column/row helpers.
package aes_pkg;
   localparam int unsigned NR    = 10;
   localparam int unsigned NK    = 4;
   localparam int unsigned IDX_W = 4;

   typedef logic [127:0] block_t;
   typedef logic [7:0]   byte_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Column bytes are ordered row 0 in the top byte.
   function automatic logic [31:0] mix_column(input logic [31:0] col);
      byte_t a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Byte k sits at [127-8k -: 8]; row r of column c is byte r+4c.
   function automatic block_t shift_rows(input block_t s);
      return {s[127:120], s[87:80],   s[47:40],   s[7:0],
              s[95:88],   s[55:48],   s[15:8],    s[103:96],
              s[63:56],   s[23:16],   s[111:104], s[71:64],
              s[31:24],   s[119:112], s[79:72],   s[39:32]};
   endfunction
endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES encryption round; MixColumns is skipped on the final round.
module aes_round_comb
   import aes_pkg::*;
(
   input  block_t i_state,
   input  block_t i_round_key,
   input  logic   i_last,
   output block_t o_state
);
   block_t w_sub;
   block_t w_shift;
   block_t w_mix;

   for (genvar g = 0; g < 16; g++) begin : g_sbox
      s_box u_s_box (
         .i_in  (i_state[8*g +: 8]),
         .o_out (w_sub[8*g +: 8])
      );
   end

   assign w_shift = shift_rows(w_sub);

   for (genvar c = 0; c < 4; c++) begin : g_mix
      assign w_mix[32*c +: 32] = mix_column(w_shift[32*c +: 32]);
   end

   assign o_state = (i_last ? w_shift : w_mix) ^ i_round_key;
endmodule

// File: rtl/s_box.sv
// AES forward S-box as a constant lookup table.
module s_box
   import aes_pkg::*;
(
   input  byte_t i_in,
   output byte_t o_out
);
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [10:0] w_idx;

   // Entry 0 occupies the top byte, so the slot for v is (255-v) = ~v.
   assign w_idx = {~i_in, 3'b000};
   assign o_out = SBOX[w_idx +: 8];
endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys fetched by index from the schedule.
module aes_enc_iter
   import aes_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             keys_valid,
   output logic [IDX_W-1:0] rk_idx,
   input  logic [127:0]     rk_data,
   input  logic             pt_valid,
   output logic             pt_ready,
   input  logic [127:0]     pt_data,
   output logic             ct_valid,
   input  logic             ct_ready,
   output logic [127:0]     ct_data,
   output logic             busy
);
   state_e           r_state;
   logic [IDX_W-1:0] r_round_cnt;
   block_t           r_aes_state;
   logic             r_ct_valid;
   logic             r_busy;
   block_t           w_round_out;
   logic             w_last;

   assign w_last = (r_round_cnt == IDX_W'(NR));

   aes_round_comb u_round (
      .i_state     (r_aes_state),
      .i_round_key (rk_data),
      .i_last      (w_last),
      .o_state     (w_round_out)
   );

   // Counter doubles as the key index: 0 in IDLE/DONE, current round in ROUND.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_round_cnt <= '0;
         r_aes_state <= '0;
         r_ct_valid  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (pt_valid && keys_valid) begin
                  r_aes_state <= pt_data ^ rk_data;
                  r_round_cnt <= IDX_W'(1);
                  r_busy      <= 1'b1;
                  r_state     <= S_ROUND;
               end
            end
            S_ROUND: begin
               r_aes_state <= w_round_out;
               if (w_last) begin
                  r_round_cnt <= '0;
                  r_ct_valid  <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_round_cnt <= r_round_cnt + IDX_W'(1);
               end
            end
            S_DONE: begin
               if (ct_ready) begin
                  r_ct_valid <= 1'b0;
                  r_busy     <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            default: begin
               r_round_cnt <= '0;
               r_ct_valid  <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign rk_idx   = r_round_cnt;
   assign ct_valid = r_ct_valid;
   assign ct_data  = r_aes_state;
   assign busy     = r_busy;

   // Follows keys_valid directly so a block arriving with the keys is taken on that edge.
   assign pt_ready = ~rst & keys_valid & (r_state == S_IDLE);
endmodule

// File: tb/tb_aes_enc_iter.sv
// Directed-vector bench for aes_enc_iter with an independent byte-level AES-128 model.
module tb_aes_enc_iter;
   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

   logic         clk;
   logic         rst;
   logic         keys_valid;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;
   logic         pt_valid;
   logic         pt_ready;
   logic [127:0] pt_data;
   logic         ct_valid;
   logic         ct_ready;
   logic [127:0] ct_data;
   logic         busy;

   logic [127:0] rk_tab [16];
   logic [7:0]   sb_tab [256];
   int           n_checks;
   int           n_fail;

   aes_enc_iter dut (
      .clk        (clk),
      .rst        (rst),
      .keys_valid (keys_valid),
      .rk_idx     (rk_idx),
      .rk_data    (rk_data),
      .pt_valid   (pt_valid),
      .pt_ready   (pt_ready),
      .pt_data    (pt_data),
      .ct_valid   (ct_valid),
      .ct_ready   (ct_ready),
      .ct_data    (ct_data),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign rk_data = rk_tab[rk_idx];

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box derived from the field inverse (x^254) and the affine map.
   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] r, base, b;
      logic [7:0] e;
      r = 8'h01; base = x; e = 8'd254;
      for (int i = 0; i < 8; i++) begin
         if (e[0]) r = gmul(r, base);
         base = gmul(base, base);
         e = e >> 1;
      end
      b = r;
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] aes_ref(input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] out;
      for (int i = 0; i < 16; i++)
         s[4'(i)] = 8'(pt >> (120 - 8*i)) ^ 8'(rk_tab[0] >> (120 - 8*i));
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) s[4'(i)] = sb_tab[s[4'(i)]];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
               t[4'(w + 4*c)] = s[4'(w + 4*((c + w) % 4))];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = t[4'(4*c)]; a1 = t[4'(4*c+1)]; a2 = t[4'(4*c+2)]; a3 = t[4'(4*c+3)];
               t[4'(4*c)]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               t[4'(4*c+1)] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               t[4'(4*c+2)] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               t[4'(4*c+3)] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         for (int i = 0; i < 16; i++)
            s[4'(i)] = t[4'(i)] ^ 8'(rk_tab[4'(r)] >> (120 - 8*i));
      end
      out = '0;
      for (int i = 0; i < 16; i++) out = {out[119:0], s[4'(i)]};
      return out;
   endfunction

   task automatic load_key(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[6'(i)] = 32'(key >> (96 - 32*i));
      for (int i = 4; i < 44; i++) begin
         t = w[6'(i-1)];
         if (i % 4 == 0) begin
            t  = {t[23:0], t[31:24]};
            t  = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[6'(i)] = w[6'(i-4)] ^ t;
      end
      for (int r = 0; r < 16; r++) begin
         if (r <= 10) rk_tab[4'(r)] = {w[6'(4*r)], w[6'(4*r+1)], w[6'(4*r+2)], w[6'(4*r+3)]};
         else         rk_tab[4'(r)] = '0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pt(input logic [127:0] pt, output bit ok);
      int n;
      pt_data = pt; pt_valid = 1'b1; ok = 1'b0; n = 0;
      #1;
      while (!pt_ready && n < 50) begin step(); n++; end
      if (pt_ready) begin ok = 1'b1; step(); end
      pt_valid = 1'b0;
   endtask

   task automatic wait_ct(output int n, output logic [127:0] ct);
      n = 0;
      while (!ct_valid && n < 40) begin step(); n++; end
      ct = ct_data;
   endtask

   task automatic finish_ct();
      ct_ready = 1'b1;
      step();
      ct_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; keys_valid = 1'b1;
      #12;
      n_checks++; if (pt_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pt_ready: got %b want 0", pt_ready); end
      n_checks++; if (ct_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ct_valid: got %b want 0", ct_valid); end
      n_checks++; if (ct_data !== 128'h0) begin n_fail++; $display("FAIL reset_ct_data: got %h want 0", ct_data); end
      n_checks++; if (rk_idx !== 4'd0) begin n_fail++; $display("FAIL reset_rk_idx: got %0d want 0", rk_idx); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      n_checks++; if (pt_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_pt_ready: got %b want 1", pt_ready); end
   endtask

   task automatic test_fips_c1();
      pt_data = PT_C1; pt_valid = 1'b1; ct_ready = 1'b0;
      #1;
      n_checks++; if (pt_ready !== 1'b1 || rk_idx !== 4'd0) begin n_fail++; $display("FAIL c1_idle: pt_ready=%b rk_idx=%0d want 1/0", pt_ready, rk_idx); end
      step();
      pt_valid = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         n_checks++; if (rk_idx !== 4'(j)) begin n_fail++; $display("FAIL c1_rk_idx: got %0d want %0d", rk_idx, j); end
         n_checks++; if (ct_valid !== 1'b0 || busy !== 1'b1 || pt_ready !== 1'b0) begin n_fail++; $display("FAIL c1_in_round %0d: ct_valid=%b busy=%b pt_ready=%b want 0/1/0", j, ct_valid, busy, pt_ready); end
         step();
      end
      n_checks++; if (ct_valid !== 1'b1) begin n_fail++; $display("FAIL c1_latency: ct_valid=%b want 1 after 10 edges", ct_valid); end
      n_checks++; if (ct_data !== CT_C1) begin n_fail++; $display("FAIL c1_ct_data: got %h want %h", ct_data, CT_C1); end
      n_checks++; if (rk_idx !== 4'd0) begin n_fail++; $display("FAIL c1_done_rk_idx: got %0d want 0", rk_idx); end
      finish_ct();
      n_checks++; if (ct_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL c1_handshake: ct_valid=%b busy=%b want 0/0", ct_valid, busy); end
   endtask

   task automatic test_keys_valid();
      bit bad_rdy, bad_busy;
      int n;
      logic [127:0] ct;
      bad_rdy = 0; bad_busy = 0;
      keys_valid = 1'b0; pt_data = PT_C1; pt_valid = 1'b1;
      #1;
      for (int k = 0; k < 8; k++) begin
         if (pt_ready !== 1'b0) bad_rdy = 1;
         if (busy !== 1'b0) bad_busy = 1;
         step();
      end
      n_checks++; if (bad_rdy) begin n_fail++; $display("FAIL kv_pt_ready: got 1 want 0 while keys_valid=0"); end
      n_checks++; if (bad_busy) begin n_fail++; $display("FAIL kv_accepted: got busy=1 want 0 while keys_valid=0"); end
      keys_valid = 1'b1;
      #1;
      n_checks++; if (pt_ready !== 1'b1) begin n_fail++; $display("FAIL kv_rise_pt_ready: got %b want 1", pt_ready); end
      step();
      pt_valid = 1'b0;
      n_checks++; if (busy !== 1'b1 || rk_idx !== 4'd1) begin n_fail++; $display("FAIL kv_accept_edge: busy=%b rk_idx=%0d want 1/1", busy, rk_idx); end
      wait_ct(n, ct);
      n_checks++; if (n !== 10 || ct !== CT_C1) begin n_fail++; $display("FAIL kv_result: latency=%0d ct=%h want 10/%h", n, ct, CT_C1); end
      finish_ct();
   endtask

   task automatic test_backpressure();
      bit ok, bad_v, bad_d, bad_r;
      int n;
      logic [127:0] ct, exp2;
      bad_v = 0; bad_d = 0; bad_r = 0;
      exp2 = aes_ref(PT_B);
      send_pt(PT_C1, ok);
      wait_ct(n, ct);
      n_checks++; if (!ok || n !== 10 || ct !== CT_C1) begin n_fail++; $display("FAIL bp_first: ok=%b latency=%0d ct=%h want 1/10/%h", ok, n, ct, CT_C1); end
      pt_data = PT_B; pt_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (ct_valid !== 1'b1) bad_v = 1;
         if (ct_data !== CT_C1) bad_d = 1;
         if (pt_ready !== 1'b0) bad_r = 1;
         step();
      end
      n_checks++; if (bad_v) begin n_fail++; $display("FAIL bp_ct_valid: dropped, want 1 during stall"); end
      n_checks++; if (bad_d) begin n_fail++; $display("FAIL bp_ct_data: changed, want %h during stall", CT_C1); end
      n_checks++; if (bad_r) begin n_fail++; $display("FAIL bp_pt_ready: got 1 want 0 during stall"); end
      ct_ready = 1'b1;
      step();
      ct_ready = 1'b0;
      n_checks++; if (ct_valid !== 1'b0 || busy !== 1'b0 || pt_ready !== 1'b1) begin n_fail++; $display("FAIL bp_after_hs: ct_valid=%b busy=%b pt_ready=%b want 0/0/1", ct_valid, busy, pt_ready); end
      step();
      pt_valid = 1'b0;
      n_checks++; if (busy !== 1'b1 || rk_idx !== 4'd1) begin n_fail++; $display("FAIL bp_second_accept: busy=%b rk_idx=%0d want 1/1", busy, rk_idx); end
      wait_ct(n, ct);
      n_checks++; if (n !== 10 || ct !== exp2) begin n_fail++; $display("FAIL bp_second_ct: latency=%0d ct=%h want 10/%h", n, ct, exp2); end
      finish_ct();
   endtask

   task automatic test_reset_mid();
      bit ok, saw_ct;
      int n;
      logic [127:0] ct;
      saw_ct = 0;
      send_pt(PT_C1, ok);
      for (int k = 0; k < 4; k++) step();
      n_checks++; if (!ok || rk_idx !== 4'd5) begin n_fail++; $display("FAIL rm_round5: ok=%b rk_idx=%0d want 1/5", ok, rk_idx); end
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (pt_ready !== 1'b0 || ct_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rm_async_ctrl: pt_ready=%b ct_valid=%b busy=%b want 0/0/0", pt_ready, ct_valid, busy); end
      n_checks++; if (ct_data !== 128'h0 || rk_idx !== 4'd0) begin n_fail++; $display("FAIL rm_async_data: ct_data=%h rk_idx=%0d want 0/0", ct_data, rk_idx); end
      for (int k = 0; k < 3; k++) begin if (ct_valid !== 1'b0) saw_ct = 1; step(); end
      @(posedge clk); #3;
      rst = 1'b0;
      for (int k = 0; k < 15; k++) begin if (ct_valid !== 1'b0 || busy !== 1'b0) saw_ct = 1; step(); end
      n_checks++; if (saw_ct) begin n_fail++; $display("FAIL rm_no_ct: aborted block raised ct_valid/busy, want 0"); end
      send_pt(PT_C1, ok);
      wait_ct(n, ct);
      n_checks++; if (!ok || n !== 10 || ct !== CT_C1) begin n_fail++; $display("FAIL rm_recover: ok=%b latency=%0d ct=%h want 1/10/%h", ok, n, ct, CT_C1); end
      finish_ct();
   endtask

   task automatic test_fips_b();
      bit ok;
      int n;
      logic [127:0] ct;
      load_key(KEY_B);
      send_pt(PT_B, ok);
      wait_ct(n, ct);
      n_checks++; if (!ok || n !== 10) begin n_fail++; $display("FAIL b_latency: ok=%b latency=%0d want 1/10", ok, n); end
      n_checks++; if (ct !== CT_B) begin n_fail++; $display("FAIL b_ct_data: got %h want %h", ct, CT_B); end
      finish_ct();
   endtask

   task automatic test_back_to_back();
      logic [127:0] bb_pt [4];
      logic [127:0] got [4];
      int acc_t [4];
      int n_acc, n_ct, cyc;
      bit acc, hs;
      for (int k = 0; k < 4; k++) bb_pt[k] = {$urandom, $urandom, $urandom, $urandom};
      n_acc = 0; n_ct = 0; cyc = 0;
      pt_data = bb_pt[0]; pt_valid = 1'b1; ct_ready = 1'b1;
      #1;
      while (n_ct < 4 && cyc < 100) begin
         acc = pt_valid && pt_ready;
         hs  = ct_valid && ct_ready;
         if (hs) begin got[n_ct] = ct_data; n_ct++; end
         step();
         cyc++;
         if (acc) begin
            acc_t[n_acc] = cyc; n_acc++;
            if (n_acc < 4) pt_data = bb_pt[n_acc];
            else           pt_valid = 1'b0;
         end
      end
      pt_valid = 1'b0; ct_ready = 1'b0;
      n_checks++; if (n_ct !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d results want 4 within 100 cycles", n_ct); end
      for (int k = 0; k < n_ct; k++) begin
         n_checks++; if (got[k] !== aes_ref(bb_pt[k])) begin n_fail++; $display("FAIL b2b_ct[%0d]: got %h want %h", k, got[k], aes_ref(bb_pt[k])); end
      end
      for (int k = 1; k < n_acc; k++) begin
         n_checks++; if (acc_t[k] - acc_t[k-1] !== 12) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want 12", k, acc_t[k] - acc_t[k-1]); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      n_checks = 0; n_fail = 0;
      rst = 1'b1; keys_valid = 1'b0; pt_valid = 1'b0; ct_ready = 1'b0; pt_data = '0;
      for (int i = 0; i < 256; i++) sb_tab[8'(i)] = sbox_calc(8'(i));
      load_key(KEY_C1);
      test_reset();
      test_fips_c1();
      test_keys_valid();
      test_backpressure();
      test_reset_mid();
      test_fips_b();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/aes_enc_iter.md
Name: aes_enc_iter

Overview:
- Iterative AES-128 encryption datapath. Sits directly downstream of the round-key schedule and consumes its round keys.
- Accepts one 128-bit plaintext block per transaction over a valid/ready handshake and executes one AES round per clock.
- Fetches each round key by index from the schedule's key storage and returns the ciphertext over a valid/ready handshake.
- Encrypt only. Decryption is a separate block.

Parameters:
- NR, 10, number of AES rounds; fixed at 10 for AES-128, other values unsupported.
- IDX_W, 4, width of the round-key index.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- keys_valid  input  1  all 11 round keys are stable in the schedule's storage.
- rk_idx  output  IDX_W  round-key index requested, 0..10.
- rk_data  input  128  round key for rk_idx, valid combinationally in the same cycle.
- pt_valid  input  1  plaintext available.
- pt_ready  output  1  block can accept plaintext.
- pt_data  input  128  plaintext; bit 127 is byte 0; column-major AES state.
- ct_valid  output  1  ciphertext available.
- ct_ready  input  1  consumer accepts ciphertext.
- ct_data  output  128  ciphertext, same byte order as pt_data.
- busy  output  1  a block is in flight (ROUND or DONE).

Behaviour:
- Reset is asynchronous: rst high forces the following immediately, independent of clk.
  - state=IDLE, round_cnt=0, state register=0.
  - pt_ready=0, ct_valid=0, ct_data=0, rk_idx=0, busy=0.
- States:
  - IDLE: pt_ready = keys_valid; rk_idx=0.
    - On pt_valid&pt_ready at an edge: state_reg <= pt_data ^ rk_data (initial AddRoundKey); round_cnt <= 1; go to ROUND.
  - ROUND: pt_ready=0; rk_idx=round_cnt.
    - Each edge: state_reg <= round(state_reg, rk_data); round_cnt <= round_cnt+1.
    - round = SubBytes, ShiftRows, MixColumns, AddRoundKey.
    - When round_cnt==NR, MixColumns is bypassed and the FSM goes to DONE.
  - DONE: ct_valid=1; ct_data=state_reg; held stable until ct_ready.
    - On ct_valid&ct_ready at an edge: go to IDLE, ct_valid <= 0.
- Latency: ct_valid rises exactly NR edges after the plaintext acceptance edge (10 for AES-128), with ct_ready ignored until then. Throughput is 1 block per ≥12 cycles.
- No pipelining: pt_ready=0 in ROUND and DONE. A plaintext presented then is held off and not dropped.
- keys_valid:
  - Sampled only in IDLE.
  - A drop mid-operation does not abort the block; the result is then undefined but the FSM completes normally.
  - The upstream schedule must not regenerate keys while busy=1.
- round_cnt never exceeds NR. An index >10 is never driven on rk_idx.
- ct_ready held high before DONE has no effect. The ct handshake completes on the first edge in DONE where ct_ready=1.
- rst asserted mid-round aborts the block, discards the state and returns to IDLE. No ct_valid results from the aborted block.
- Simultaneous pt_valid and keys_valid rising in the same cycle: accepted at that edge, since pt_ready is combinational from keys_valid.

Decomposition:
- Shared package aes_pkg:
  - Constants NR=10, NK=4, IDX_W=4.
  - 128-bit block typedef and 8-bit byte typedef.
  - Functions xtime and mix_column (32-bit).
  - Function shift_rows (pure rewiring).
- One sub-module, aes_round_comb:
  - Combinational: state_in, round_key, last → state_out.
  - Instantiates 16 existing s_box cells, then shift_rows, then mix_column ×4 (bypassed when last), then XOR with round_key.
- aes_enc_iter holds only the FSM, the counter, the state register and the handshakes.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, keys_valid=1; pt 00112233445566778899aabbccddeeff → ct_valid exactly 10 edges after acceptance, ct_data=69c4e0d86a7b0430d8cdb78070b4c55a. rk_idx sequence 0,1..10 checked.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → ct 3925841d02dc09fbdc118597196a0b32.
- Backpressure: ct_ready=0 for 5 cycles after ct_valid → ct_data stable, pt_ready=0 throughout; second pt_valid held is accepted one cycle after the ct handshake.
- keys_valid=0 with pt_valid=1 for 8 cycles → pt_ready=0 and no acceptance; keys_valid rises → accepted on that edge.
- Reset mid-operation: assert rst asynchronously at round 5 → outputs are at reset values before the next clk edge, ct_valid is never asserted, and the next block completes correctly with the C.1 vector.
- Back-to-back: 4 random blocks with ct_ready=1 and pt_valid=1 continuously → results match the reference model, with 12 cycles between successive acceptances.
